trigger_hub_multi: RTL

Parametrised successor trigger hub for the uScope capture path. It qualifies N_SOURCES trigger inputs against a runtime enable mask. On a qualified event it waits for the capture buffer to reach a programmable pre-trigger position, then issues a one-cycle pulse on one of N_TRIGGERS outputs. It then sequences capture-done/acknowledge with inhibit, and supports single-shot, continuous and disabled modes, a programmable holdoff, explicit arm/disarm and an event counter.

---
 rtl/trigger_hub_multi.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/trigger_hub_multi.sv
// Trigger hub: qualifies masked trigger sources, fires a one-hot trigger_out pulse
// at the programmed pre-trigger buffer level, then sequences capture done/ack/holdoff.
module trigger_hub_multi #(
  parameter int N_TRIGGERS    = 16,
  parameter int N_SOURCES     = 4,
  parameter int LEVEL_WIDTH   = 16,
  parameter int HOLDOFF_WIDTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [LEVEL_WIDTH-1:0]        buffer_level,
  input  logic [N_SOURCES-1:0]          trigger_in,
  input  logic [N_SOURCES-1:0]          trigger_mask,
  input  logic [$clog2(N_TRIGGERS)-1:0] selected_trigger,
  input  logic [1:0]                    mode,
  input  logic                          arm,
  input  logic                          disarm,
  input  logic [HOLDOFF_WIDTH-1:0]      holdoff,
  input  logic [LEVEL_WIDTH-1:0]        trigger_position,
  input  logic                          capture_done,
  input  logic                          capture_ack,
  output logic                          capture_inhibit,
  output logic [N_TRIGGERS-1:0]         trigger_out,
  output logic [2:0]                    state_out,
  output logic [31:0]                   trigger_count
);

  localparam int SEL_W = $clog2(N_TRIGGERS);
  // One extra bit so the range check stays meaningful when N_TRIGGERS is a power of two.
  localparam logic [SEL_W:0] SEL_LIMIT = (SEL_W + 1)'(N_TRIGGERS);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    PENDING   = 3'd2,
    WAIT_DONE = 3'd3,
    WAIT_ACK  = 3'd4,
    HOLDOFF   = 3'd5
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [SEL_W-1:0]         r_index;
  logic [HOLDOFF_WIDTH-1:0] r_holdoff_cnt;
  logic [N_TRIGGERS-1:0]    r_trigger_out;
  logic                     r_capture_inhibit;
  logic [31:0]              r_trigger_count;

  logic                     w_event;
  logic                     w_sel_valid;
  logic                     w_mode_run;
  logic                     w_level_match;
  logic                     w_holdoff_last;
  state_t                   w_rearm_state;

  logic                     w_fire;
  logic                     w_latch_index;
  logic                     w_capture_start;
  logic                     w_ack;
  logic                     w_holdoff_load;
  logic [N_TRIGGERS-1:0]    w_onehot;

  assign w_event        = |(trigger_in & trigger_mask);
  assign w_sel_valid    = ({1'b0, selected_trigger} < SEL_LIMIT);
  assign w_mode_run     = ~mode[1];
  assign w_level_match  = (buffer_level == trigger_position);
  assign w_holdoff_last = (r_holdoff_cnt == HOLDOFF_WIDTH'(1));
  assign w_rearm_state  = (mode == 2'd0) ? ARMED : IDLE;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (arm && !disarm && w_mode_run) w_next_state = ARMED;
      end
      ARMED: begin
        if (disarm || !w_mode_run)       w_next_state = IDLE;
        else if (w_event && w_sel_valid) w_next_state = PENDING;
      end
      PENDING: begin
        if (disarm)             w_next_state = IDLE;
        else if (w_level_match) w_next_state = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (capture_done) w_next_state = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (capture_ack) begin
          if (holdoff == '0) w_next_state = w_rearm_state;
          else               w_next_state = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (disarm)              w_next_state = IDLE;
        else if (w_holdoff_last) w_next_state = w_rearm_state;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Output / datapath control decode
  always_comb begin
    w_fire          = 1'b0;
    w_latch_index   = 1'b0;
    w_capture_start = 1'b0;
    w_ack           = 1'b0;
    w_holdoff_load  = 1'b0;
    w_onehot        = {{(N_TRIGGERS-1){1'b0}}, 1'b1} << r_index;
    unique case (r_state)
      ARMED:     w_latch_index   = (w_next_state == PENDING);
      PENDING:   w_fire          = !disarm && w_level_match;
      WAIT_DONE: w_capture_start = capture_done;
      WAIT_ACK: begin
        w_ack          = capture_ack;
        w_holdoff_load = capture_ack && (holdoff != '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_index           <= '0;
      r_holdoff_cnt     <= '0;
      r_trigger_out     <= '0;
      r_capture_inhibit <= 1'b0;
      r_trigger_count   <= '0;
    end else begin
      r_trigger_out <= w_fire ? w_onehot : '0;
      if (w_latch_index) r_index <= selected_trigger;
      if (w_capture_start)  r_capture_inhibit <= 1'b1;
      else if (w_ack)       r_capture_inhibit <= 1'b0;
      if (w_ack) r_trigger_count <= r_trigger_count + 32'd1;
      if (w_holdoff_load)            r_holdoff_cnt <= holdoff;
      else if (r_state == HOLDOFF)   r_holdoff_cnt <= r_holdoff_cnt - HOLDOFF_WIDTH'(1);
    end
  end

  assign state_out       = r_state;
  assign trigger_out     = r_trigger_out;
  assign capture_inhibit = r_capture_inhibit;
  assign trigger_count   = r_trigger_count;

endmodule
